hazard_forward_ctrl: RTL and testbench
======================================

# hazard_forward_ctrl

Parametrised forwarding and hazard controller for the 5-stage RV32 pipeline. It generalises operand forwarding to `NUM_SRC` source operands and adds load-use stall detection and a full-pipeline freeze while a multi-cycle data-memory load is outstanding. It also provides a load-wait watchdog and a saturating stall-cycle counter. It sits beside the ID/EX/MEM/WB pipeline registers and drives their stall/flush/freeze enables and the EX-stage operand muxes.

## Interface
- `REG_ADDR_W`, 5, register address width
- `NUM_SRC`, 2, source operands per instruction
- `MEM_TIMEOUT`, 16, max cycles a load may wait on `dmem_ready` before error
- `STALL_CNT_W`, 32, stall counter width

Ports:
- `clk`  in  1  clock; single clock domain
- `rst`  in  1  reset, asynchronous, active-high
- `if_id_rs`  in  NUM_SRC×REG_ADDR_W  source regs of the instruction in ID
- `if_id_rs_used`  in  NUM_SRC  per-operand valid mask for ID instruction
- `id_ex_rs`  in  NUM_SRC×REG_ADDR_W  source regs of the instruction in EX
- `id_ex_rd`  in  REG_ADDR_W  destination in ID/EX
- `id_ex_mem_read`  in  1  ID/EX instruction is a load
- `ex_mem_rd`  in  REG_ADDR_W  destination in EX/MEM
- `ex_mem_reg_write`  in  1  EX/MEM writes rd
- `ex_mem_mem_read`  in  1  EX/MEM instruction is a load
- `mem_wb_rd`  in  REG_ADDR_W  destination in MEM/WB
- `mem_wb_reg_write`  in  1  MEM/WB writes rd
- `dmem_ready`  in  1  data memory returns load data this cycle
- `fwd_sel`  out  NUM_SRC×2  per-operand EX mux select
- `stall_pc`  out  1  hold PC
- `stall_if_id`  out  1  hold IF/ID
- `flush_id_ex`  out  1  insert bubble into ID/EX
- `freeze`  out  1  hold PC, IF/ID, ID/EX, EX/MEM, MEM/WB
- `mem_timeout_err`  out  1  sticky watchdog error
- `stall_cnt`  out  STALL_CNT_W  saturating count of stalled cycles

## Operation
- Forwarding, per operand i: `2'b10` if `ex_mem_reg_write && ex_mem_rd!=0 && ex_mem_rd==id_ex_rs[i]`; else `2'b01` if the same condition holds on MEM/WB; else `2'b00`. EX/MEM always wins. x0 is never forwarded.
- Load-use: `lu = id_ex_mem_read && id_ex_rd!=0 && any i (if_id_rs_used[i] && if_id_rs[i]==id_ex_rd)`.
- Mem wait: `mw = ex_mem_mem_read && !dmem_ready`.
- Priority: `freeze = mw`.
- `stall_pc = stall_if_id = mw || lu`.
- `flush_id_ex = lu && !mw`. No bubble is inserted while frozen, and ID/EX is held.
- FSM `hz_state_e` has two states, IDLE and MEM_WAIT:
  - IDLE→MEM_WAIT when `mw`.
  - MEM_WAIT→IDLE when `dmem_ready` or `!ex_mem_mem_read`.
  - MEM_WAIT→MEM_WAIT otherwise.
- `wait_cnt` is cleared in IDLE and increments each cycle in MEM_WAIT, saturating at MEM_TIMEOUT. Width is `$clog2(MEM_TIMEOUT+1)`.
- Watchdog: when `wait_cnt==MEM_TIMEOUT-1` and `mw` is still true, set `mem_timeout_err` at the next edge. It stays sticky until `rst`. Freeze continues regardless.
- `stall_cnt` increments on every cycle with `stall_pc`=1. It saturates at all-ones and does not wrap.

## Timing
- `fwd_sel`, `stall_*`, `flush_id_ex` and `freeze` are combinational from their inputs, with zero latency in the same cycle.
- State, `wait_cnt`, `mem_timeout_err` and `stall_cnt` update on the rising edge of `clk`.
- Reset value, while `rst`=1:
  - state IDLE, `wait_cnt`=0, `mem_timeout_err`=0, `stall_cnt`=0.
  - `stall_pc`, `stall_if_id`, `flush_id_ex` and `freeze` are forced to 0.
  - `fwd_sel` is forced to 0.
- Reset mid-wait aborts MEM_WAIT immediately and clears both counters and the error.
- Load-use lasts exactly 1 cycle per hazard. The bubble moves the load to MEM, which clears `lu`.
- `dmem_ready`=1 on the first MEM cycle of a load means no freeze and no MEM_WAIT entry.
- Simultaneous `lu` and `mw`: freeze only, with `flush_id_ex`=0. `lu` is re-evaluated after release.
- `stall_cnt` counts a cycle with both `lu` and `mw` once.

## Structure
- `hazard_pkg` holds:
  - enum `fwd_sel_e` with `FWD_RF=2'b00`, `FWD_MEM_WB=2'b01`, `FWD_EX_MEM=2'b10`.
  - enum `hz_state_e`.
- Sub-module `fwd_select`: one operand's comparator and priority logic. It is instantiated NUM_SRC times via generate.
- `hazard_forward_ctrl` holds the load-use reduction, FSM, watchdog and counter.

## Test plan
- EX/MEM and MEM/WB both write x5, and `id_ex_rs[0]`=5 → `fwd_sel[0]`=`2'b10`. With `ex_mem_reg_write`=0 → `2'b01`. With rd=0 → `2'b00`.
- Load to x7 in ID/EX, `if_id_rs[1]`=7 with `used[1]`=1 → 1 cycle of `stall_pc`/`stall_if_id`/`flush_id_ex`, and `stall_cnt` goes 0→1. With `used[1]`=0 → no stall.
- Load in EX/MEM with `dmem_ready` low for 3 cycles → `freeze`=1 for exactly 3 cycles, `flush_id_ex`=0 throughout, and `stall_cnt`=3.
- `dmem_ready` held low with MEM_TIMEOUT=4 → `mem_timeout_err` rises after the 4th wait cycle, freeze persists, and the error stays set after ready returns.
- `rst` asserted during MEM_WAIT → all outputs 0 at once and the state is IDLE. With STALL_CNT_W=3 and 10 stall cycles → `stall_cnt`=7.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the forwarding and hazard controller
package hazard_pkg;
    typedef enum logic [1:0] {
        FWD_RF     = 2'b00,
        FWD_MEM_WB = 2'b01,
        FWD_EX_MEM = 2'b10
    } fwd_sel_e;
    typedef enum logic {
        IDLE,
        MEM_WAIT
    } hz_state_e;
endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// fwd_select: EX-stage forwarding priority for one source operand
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [REG_ADDR_W-1:0] ex_mem_rd,
    input  logic                  ex_mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_wb_rd,
    input  logic                  mem_wb_reg_write,
    output logic [1:0]            sel
);
    logic ex_hit, wb_hit;
    always_comb begin
        ex_hit = ex_mem_reg_write && ex_mem_rd != '0 && ex_mem_rd == rs;
        wb_hit = mem_wb_reg_write && mem_wb_rd != '0 && mem_wb_rd == rs;
        sel    = ex_hit ? FWD_EX_MEM : wb_hit ? FWD_MEM_WB : FWD_RF;
    end
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: operand forwarding, load-use stall, load-wait freeze, watchdog and stall counter
module hazard_forward_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W  = 5,
    parameter int NUM_SRC     = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int STALL_CNT_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] if_id_rs,
    input  logic [NUM_SRC-1:0]            if_id_rs_used,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_ex_rs,
    input  logic [REG_ADDR_W-1:0]         id_ex_rd,
    input  logic                          id_ex_mem_read,
    input  logic [REG_ADDR_W-1:0]         ex_mem_rd,
    input  logic                          ex_mem_reg_write,
    input  logic                          ex_mem_mem_read,
    input  logic [REG_ADDR_W-1:0]         mem_wb_rd,
    input  logic                          mem_wb_reg_write,
    input  logic                          dmem_ready,
    output logic [NUM_SRC*2-1:0]          fwd_sel,
    output logic                          stall_pc,
    output logic                          stall_if_id,
    output logic                          flush_id_ex,
    output logic                          freeze,
    output logic                          mem_timeout_err,
    output logic [STALL_CNT_W-1:0]        stall_cnt
);
    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    hz_state_e                state_q, state_d;
    logic [WC_W-1:0]          wait_cnt_q, wait_cnt_d;
    logic                     err_q, err_d;
    logic [STALL_CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [NUM_SRC-1:0]       rs_hit;
    logic [NUM_SRC*2-1:0]     sel_raw;
    logic                     lu, mw, stall;
    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd (
            .rs              (id_ex_rs[i*REG_ADDR_W +: REG_ADDR_W]),
            .ex_mem_rd       (ex_mem_rd),
            .ex_mem_reg_write(ex_mem_reg_write),
            .mem_wb_rd       (mem_wb_rd),
            .mem_wb_reg_write(mem_wb_reg_write),
            .sel             (sel_raw[2*i +: 2])
        );
        assign rs_hit[i] = if_id_rs_used[i] && if_id_rs[i*REG_ADDR_W +: REG_ADDR_W] == id_ex_rd;
    end
    always_comb begin
        lu          = id_ex_mem_read && id_ex_rd != '0 && |rs_hit;
        mw          = ex_mem_mem_read && !dmem_ready;
        stall       = !rst && (mw || lu);
        stall_pc    = stall;
        stall_if_id = stall;
        flush_id_ex = !rst && lu && !mw;
        freeze      = !rst && mw;
        fwd_sel     = rst ? '0 : sel_raw;
        state_d     = state_q == IDLE ? (mw ? MEM_WAIT : IDLE)
                                      : ((dmem_ready || !ex_mem_mem_read) ? IDLE : MEM_WAIT);
        // the count includes the cycle that enters MEM_WAIT, so it equals wait cycles elapsed
        wait_cnt_d  = state_d != MEM_WAIT ? '0
                    : wait_cnt_q == WC_W'(MEM_TIMEOUT) ? wait_cnt_q : wait_cnt_q + 1'b1;
        err_d       = err_q || (mw && wait_cnt_q == WC_W'(MEM_TIMEOUT - 1));
        stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + 1'b1 : stall_cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_cnt_q  <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign mem_timeout_err = err_q;
    assign stall_cnt       = stall_cnt_q;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed checks on a default instance and a small (MEM_TIMEOUT=4, STALL_CNT_W=3) instance
module tb_hazard_forward_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] if_id_rs, id_ex_rs;
    logic [1:0] if_id_rs_used;
    logic [4:0] id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic       id_ex_mem_read, ex_mem_reg_write, ex_mem_mem_read, mem_wb_reg_write, dmem_ready;
    logic [3:0] fwd_sel, fwd_sel_s;
    logic       stall_pc, stall_if_id, flush_id_ex, freeze, err;
    logic       stall_pc_s, stall_if_id_s, flush_id_ex_s, freeze_s, err_s;
    logic [31:0] cnt;
    logic [2:0]  cnt_s;
    logic [3:0]  ctl, ctl_s;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    assign ctl   = {stall_pc, stall_if_id, flush_id_ex, freeze};
    assign ctl_s = {stall_pc_s, stall_if_id_s, flush_id_ex_s, freeze_s};
    hazard_forward_ctrl dut (
        .clk(clk), .rst(rst), .if_id_rs(if_id_rs), .if_id_rs_used(if_id_rs_used),
        .id_ex_rs(id_ex_rs), .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .dmem_ready(dmem_ready),
        .fwd_sel(fwd_sel), .stall_pc(stall_pc), .stall_if_id(stall_if_id), .flush_id_ex(flush_id_ex),
        .freeze(freeze), .mem_timeout_err(err), .stall_cnt(cnt)
    );
    hazard_forward_ctrl #(.MEM_TIMEOUT(4), .STALL_CNT_W(3)) dut_s (
        .clk(clk), .rst(rst), .if_id_rs(if_id_rs), .if_id_rs_used(if_id_rs_used),
        .id_ex_rs(id_ex_rs), .id_ex_rd(id_ex_rd), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_rd(ex_mem_rd), .ex_mem_reg_write(ex_mem_reg_write), .ex_mem_mem_read(ex_mem_mem_read),
        .mem_wb_rd(mem_wb_rd), .mem_wb_reg_write(mem_wb_reg_write), .dmem_ready(dmem_ready),
        .fwd_sel(fwd_sel_s), .stall_pc(stall_pc_s), .stall_if_id(stall_if_id_s), .flush_id_ex(flush_id_ex_s),
        .freeze(freeze_s), .mem_timeout_err(err_s), .stall_cnt(cnt_s)
    );
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic clear();
        if_id_rs = '0; id_ex_rs = '0; if_id_rs_used = '0;
        id_ex_rd = '0; ex_mem_rd = '0; mem_wb_rd = '0;
        id_ex_mem_read = 0; ex_mem_reg_write = 0; ex_mem_mem_read = 0;
        mem_wb_reg_write = 0; dmem_ready = 1;
    endtask
    task automatic test_reset();
        clear();
        ex_mem_mem_read = 1; dmem_ready = 0;
        id_ex_mem_read = 1; id_ex_rd = 7; if_id_rs = {5'd7, 5'd7}; if_id_rs_used = 2'b11;
        ex_mem_reg_write = 1; ex_mem_rd = 7; id_ex_rs = {5'd7, 5'd7};
        step(); step();
        checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL reset_ctl got=%b exp=0000", ctl); end
        checks++; if (ctl_s !== 4'b0000) begin errors++; $display("FAIL reset_ctl_s got=%b exp=0000", ctl_s); end
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL reset_fwd got=%b exp=0000", fwd_sel); end
        checks++; if ({err, err_s} !== 2'b00) begin errors++; $display("FAIL reset_err got=%b exp=00", {err, err_s}); end
        checks++; if (cnt !== 32'd0 || cnt_s !== 3'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", cnt, cnt_s); end
        clear();
        rst = 0;
        step();
    endtask
    task automatic test_forward();
        clear();
        ex_mem_reg_write = 1; ex_mem_rd = 5; mem_wb_reg_write = 1; mem_wb_rd = 5;
        id_ex_rs = {5'd3, 5'd5};
        #1;
        checks++; if (fwd_sel !== 4'b0010) begin errors++; $display("FAIL fwd_ex_wins got=%b exp=0010", fwd_sel); end
        ex_mem_reg_write = 0;
        #1;
        checks++; if (fwd_sel !== 4'b0001) begin errors++; $display("FAIL fwd_mem_wb got=%b exp=0001", fwd_sel); end
        ex_mem_reg_write = 1; ex_mem_rd = 0; mem_wb_rd = 0; id_ex_rs = {5'd0, 5'd0};
        #1;
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL fwd_x0 got=%b exp=0000", fwd_sel); end
        ex_mem_rd = 5; mem_wb_rd = 9; id_ex_rs = {5'd9, 5'd5};
        #1;
        checks++; if (fwd_sel !== 4'b0110) begin errors++; $display("FAIL fwd_split got=%b exp=0110", fwd_sel); end
        ex_mem_rd = 9;
        #1;
        checks++; if (fwd_sel !== 4'b1000) begin errors++; $display("FAIL fwd_op1_ex got=%b exp=1000", fwd_sel); end
        clear();
        step();
    endtask
    task automatic test_load_use();
        clear();
        id_ex_mem_read = 1; id_ex_rd = 7; if_id_rs = {5'd7, 5'd3}; if_id_rs_used = 2'b10;
        #1;
        checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL lu_stall got=%b exp=1110", ctl); end
        step();
        checks++; if (cnt !== 32'd1 || cnt_s !== 3'd1) begin errors++; $display("FAIL lu_cnt got=%0d/%0d exp=1/1", cnt, cnt_s); end
        id_ex_mem_read = 0; ex_mem_mem_read = 1; ex_mem_rd = 7; dmem_ready = 1;
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL lu_bubble got=%b exp=0000", ctl); end
        step();
        clear();
        id_ex_mem_read = 1; id_ex_rd = 7; if_id_rs = {5'd7, 5'd3}; if_id_rs_used = 2'b01;
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL lu_unused got=%b exp=0000", ctl); end
        id_ex_rd = 0; if_id_rs = '0; if_id_rs_used = 2'b11;
        #1;
        checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL lu_x0 got=%b exp=0000", ctl); end
        step();
        checks++; if (cnt !== 32'd1) begin errors++; $display("FAIL lu_cnt_hold got=%0d exp=1", cnt); end
        clear();
    endtask
    task automatic test_mem_wait();
        clear();
        ex_mem_mem_read = 1; dmem_ready = 0;
        id_ex_mem_read = 1; id_ex_rd = 7; if_id_rs = {5'd7, 5'd3}; if_id_rs_used = 2'b10;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (ctl !== 4'b1101) begin errors++; $display("FAIL mw_freeze cyc=%0d got=%b exp=1101", c, ctl); end
            step();
        end
        dmem_ready = 1;
        #1;
        checks++; if (ctl !== 4'b1110) begin errors++; $display("FAIL mw_release_lu got=%b exp=1110", ctl); end
        step();
        checks++; if (cnt !== 32'd5 || cnt_s !== 3'd5) begin errors++; $display("FAIL mw_cnt got=%0d/%0d exp=5/5", cnt, cnt_s); end
        checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL mw_no_err got=%b exp=0", err_s); end
        clear();
        step();
    endtask
    task automatic test_timeout();
        clear();
        ex_mem_mem_read = 1; dmem_ready = 0;
        for (int c = 1; c <= 16; c++) begin
            step();
            if (c == 3) begin
                checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL to_early_s got=%b exp=0", err_s); end
            end
            if (c == 4) begin
                checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL to_rise_s got=%b exp=1", err_s); end
                checks++; if (ctl_s !== 4'b1101) begin errors++; $display("FAIL to_freeze_s got=%b exp=1101", ctl_s); end
            end
            if (c == 15) begin
                checks++; if (err !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", err); end
            end
        end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL to_rise got=%b exp=1", err); end
        dmem_ready = 1;
        step();
        checks++; if ({err, err_s} !== 2'b11) begin errors++; $display("FAIL to_sticky got=%b exp=11", {err, err_s}); end
        checks++; if (ctl !== 4'b0000) begin errors++; $display("FAIL to_release got=%b exp=0000", ctl); end
        checks++; if (cnt !== 32'd21 || cnt_s !== 3'd7) begin errors++; $display("FAIL to_cnt got=%0d/%0d exp=21/7", cnt, cnt_s); end
        clear();
    endtask
    task automatic test_reset_mid_wait();
        clear();
        ex_mem_mem_read = 1; dmem_ready = 0; ex_mem_reg_write = 1; ex_mem_rd = 4; id_ex_rs = {5'd4, 5'd4};
        step(); step();
        rst = 1;
        #1;
        checks++; if (ctl !== 4'b0000 || ctl_s !== 4'b0000) begin errors++; $display("FAIL rmw_ctl got=%b/%b exp=0000/0000", ctl, ctl_s); end
        checks++; if (fwd_sel !== 4'b0000) begin errors++; $display("FAIL rmw_fwd got=%b exp=0000", fwd_sel); end
        checks++; if ({err, err_s} !== 2'b00) begin errors++; $display("FAIL rmw_err got=%b exp=00", {err, err_s}); end
        checks++; if (cnt !== 32'd0 || cnt_s !== 3'd0) begin errors++; $display("FAIL rmw_cnt got=%0d/%0d exp=0/0", cnt, cnt_s); end
        step();
        rst = 0;
        for (int c = 1; c <= 4; c++) begin
            step();
            if (c == 3) begin
                checks++; if (err_s !== 1'b0) begin errors++; $display("FAIL rmw_wd_early got=%b exp=0", err_s); end
            end
        end
        checks++; if (err_s !== 1'b1) begin errors++; $display("FAIL rmw_wd_rise got=%b exp=1", err_s); end
        clear();
    endtask
    task automatic test_stall_sat();
        clear();
        rst = 1;
        #2;
        rst = 0;
        id_ex_mem_read = 1; id_ex_rd = 12; if_id_rs = {5'd1, 5'd12}; if_id_rs_used = 2'b01;
        for (int c = 0; c < 10; c++) step();
        checks++; if (cnt !== 32'd10) begin errors++; $display("FAIL sat_cnt got=%0d exp=10", cnt); end
        checks++; if (cnt_s !== 3'd7) begin errors++; $display("FAIL sat_cnt_s got=%0d exp=7", cnt_s); end
        clear();
        step();
    endtask
    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_mem_wait();
        test_timeout();
        test_reset_mid_wait();
        test_stall_sat();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
